// File: rtl/mul_hilo_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
package mul_hilo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_e;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  localparam int unsigned DEF_WIDTH = 32;

  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mul_hilo_sequencer_step.sv
// One shift-add iteration: conditionally accumulate the multiplicand, then
// advance the multiplicand left and the multiplier right.
module mul_shift_add_step
  import mul_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [prod_w(WIDTH)-1:0] acc_i,
  input  logic [prod_w(WIDTH)-1:0] mcand_i,
  input  logic [WIDTH-1:0]         mplier_i,
  output logic [prod_w(WIDTH)-1:0] acc_o,
  output logic [prod_w(WIDTH)-1:0] mcand_o,
  output logic [WIDTH-1:0]         mplier_o
);

  always_comb begin
    acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end

endmodule

// File: rtl/mul_hilo_sequencer.sv
// Multi-cycle unsigned multiply with HI/LO result registers; stalls the core
// while a read or a new multiply cannot yet be served in order.
module mul_hilo_sequencer
  import mul_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW    = prod_w(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mul_state_e        state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic [PW-1:0]     step_acc;
  logic [PW-1:0]     step_mcand;
  logic [WIDTH-1:0]  step_mplier;

  mul_shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (step_acc),
    .mcand_o  (step_mcand),
    .mplier_o (step_mplier)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, opa};
          mplier_d = opb;
          count_d  = CNT_W'(WIDTH);
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        count_d  = count_q - 1'b1;
        // Last iteration: commit the product straight from the adder output.
        if (count_q == CNT_W'(1)) begin
          hi_d    = step_acc[PW-1:WIDTH];
          lo_d    = step_acc[WIDTH-1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // A start or read arriving mid-multiply is held off until the product lands.
  always_comb begin
    busy    = (state_q == RUN);
    stall   = busy & (rd_req | start);
    rd_data = (rd_sel == RD_HI) ? hi_q : lo_q;
    hi      = hi_q;
    lo      = lo_q;
  end

endmodule

// File: doc/mul_hilo_sequencer.md
Name: mul_hilo_sequencer

Overview:
- Multi-cycle unsigned multiply unit with HI/LO result registers for the MIPS core.
- Replaces the combinational ALU multiply path.
- The decoder's multiply issue pulses start. mflo/mfhi reads arrive as rd_req/rd_sel.
- The block sequences an iterative shift-add multiply and raises stall to freeze the core while a read or a new multiply would otherwise be served out of order.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits split into HI and LO.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  issue multiply of opa*opb (multu); sampled only when not busy
- opa  in  WIDTH  multiplicand (rs)
- opb  in  WIDTH  multiplier (rt)
- rd_req  in  1  mflo/mfhi read request this cycle
- rd_sel  in  1  0 = LO (mflo), 1 = HI (mfhi)
- rd_data  out  WIDTH  selected HI/LO value; valid when rd_req & ~stall
- stall  out  1  hold the core (PC and pipeline) this cycle
- busy  out  1  multiply in progress
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high, dominates all inputs, including mid-operation):
  - state = IDLE; hi = lo = 0; busy = 0.
  - Internal accumulator, multiplicand, multiplier and count cleared.
  - Any in-flight multiply is abandoned, and hi/lo show 0 on the next cycle.
- States: IDLE, RUN.
- IDLE, start=1 at an edge:
  - Load mcand = zero-extended opa (2*WIDTH bits), mplier = opb, acc = 0, count = WIDTH.
  - Next state RUN.
- RUN, each edge:
  - If mplier[0], acc += mcand (2*WIDTH-bit add, modulo 2^(2*WIDTH), no overflow possible).
  - mcand <<= 1; mplier >>= 1; count -= 1.
  - On the edge where count goes 1 -> 0: {hi, lo} <= final acc; state -> IDLE.
- Latency is fixed and data-independent: a start sampled at edge E yields updated hi/lo visible after edge E+WIDTH. There is no early termination.
- busy = (state == RUN), registered-state decode.
- hi/lo change only on multiply completion or reset.
- Combinational outputs:
  - stall = busy & (rd_req | start).
  - rd_data = rd_sel ? hi : lo.
- Simultaneous events:
  - start while busy: ignored. stall=1 holds the instruction; the requester keeps start asserted until it is accepted in IDLE.
  - rd_req while busy: stall=1 until the cycle after completion. Then stall=0 and rd_data returns the new product.
  - rd_req and start in the same IDLE cycle: stall=0; rd_data returns the pre-multiply hi/lo, and the multiply starts.
  - rd_req on the completion edge cycle (last RUN cycle): still stalled. The read is served in the following IDLE cycle.
  - Back-to-back: a start in the first IDLE cycle after completion is accepted with no bubble.
- Operands are captured at start; changes on opa/opb during RUN have no effect.

Decomposition:
- Shared package mul_hilo_pkg:
  - state enum (IDLE, RUN).
  - RD_LO = 1'b0, RD_HI = 1'b1.
  - Product width constant (2*WIDTH).
- One natural sub-module: mul_shift_add_step, purely combinational.
  - Input: acc, mcand, mplier.
  - Output: next acc, mcand, mplier for one iteration.
  - The top level holds the FSM, counter and HI/LO registers.

Test Plan:
- Reset then start with opa=3, opb=5 -> busy=1 for 32 cycles; after edge E+32, lo=0x0000000F, hi=0; busy=0.
- opa=opb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 32 cycles; opa=0x80000000, opb=2 -> hi=1, lo=0.
- start, then rd_req=1/rd_sel=0 from the next cycle -> stall=1 for cycles E+1..E+32. stall=0 at cycle E+33 with rd_data = new lo; repeat with rd_sel=1 for hi.
- Second start pulsed during RUN with different operands -> stall=1 and no restart. After completion the held start is accepted; the second product appears 32 cycles later.
- Assert reset at RUN cycle 10 of 7*9 -> next cycle hi=lo=0, busy=0, stall=0. A new start 6*7 completes normally: lo=42.
- Same-cycle rd_req + start in IDLE with prior lo=15 -> stall=0, rd_data=15, busy=1 next cycle.
